// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU sharing controller and the ALU it fronts.
// Opcode numbering and flag bit positions must stay in step with the ALU instance.
package alu_ctrl_pkg;

    localparam int WIDTH   = 16;
    localparam int OPW     = 8;
    localparam int NUM_OPS = 22;
    localparam int FLAGW   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } ctrlState_e;

    localparam logic [OPW-1:0] OP_ADD  = 8'd0;
    localparam logic [OPW-1:0] OP_ADC  = 8'd1;
    localparam logic [OPW-1:0] OP_SUB  = 8'd2;
    localparam logic [OPW-1:0] OP_SBC  = 8'd3;
    localparam logic [OPW-1:0] OP_AND  = 8'd4;
    localparam logic [OPW-1:0] OP_OR   = 8'd5;
    localparam logic [OPW-1:0] OP_XOR  = 8'd6;
    localparam logic [OPW-1:0] OP_NOT  = 8'd7;
    localparam logic [OPW-1:0] OP_SHL  = 8'd8;
    localparam logic [OPW-1:0] OP_SHR  = 8'd9;
    localparam logic [OPW-1:0] OP_SAR  = 8'd10;
    localparam logic [OPW-1:0] OP_ROL  = 8'd11;
    localparam logic [OPW-1:0] OP_ROR  = 8'd12;
    localparam logic [OPW-1:0] OP_MOVA = 8'd13;
    localparam logic [OPW-1:0] OP_MOVB = 8'd14;
    localparam logic [OPW-1:0] OP_INC  = 8'd15;
    localparam logic [OPW-1:0] OP_DEC  = 8'd16;
    localparam logic [OPW-1:0] OP_NEG  = 8'd17;
    localparam logic [OPW-1:0] OP_CMP  = 8'd18;
    localparam logic [OPW-1:0] OP_MUL  = 8'd19;
    localparam logic [OPW-1:0] OP_MIN  = 8'd20;
    localparam logic [OPW-1:0] OP_MAX  = 8'd21;

    // Flag vector layout is {C,L,F,Z,N}, MSB first.
    localparam int FLG_N = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_F = 2;
    localparam int FLG_L = 3;
    localparam int FLG_C = 4;

endpackage

// File: rtl/alu_arb2.sv
// Two-way grant logic for the shared ALU: fixed priority to requester 0 by default,
// round-robin when ALU_SHARE_RR_EN is defined.
module alu_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] rqValid,
    input  logic       accept,
    output logic [1:0] grant
);

`ifdef ALU_SHARE_RR_EN
    logic ptr;

    always_comb begin
        grant = rqValid;
        if (rqValid == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

    // After any grant, priority moves to the requester that was not served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (accept) begin
            ptr <= ~grant[1];
        end
    end
`else
    logic unusedArbInputs;
    assign unusedArbInputs = ^{clk, rst_n, accept};

    always_comb begin
        grant = 2'b00;
        if (rqValid[0]) begin
            grant = 2'b01;
        end else if (rqValid[1]) begin
            grant = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters: IDLE accepts, EXEC lets the ALU settle,
// RESP holds the tagged response. Arbitration mode follows ALU_SHARE_RR_EN (see alu_arb2).
// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// a requester must hold its operands while valid and not ready, and may drop valid freely.
module alu_share_ctrl #(
    parameter int WIDTH   = alu_ctrl_pkg::WIDTH,
    parameter int OPW     = alu_ctrl_pkg::OPW,
    parameter int NUM_OPS = alu_ctrl_pkg::NUM_OPS,
    parameter int FLAGW   = alu_ctrl_pkg::FLAGW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       rq_valid,
    output logic [1:0]       rq_ready,
    input  logic [WIDTH-1:0] rq0_a,
    input  logic [WIDTH-1:0] rq0_b,
    input  logic [OPW-1:0]   rq0_op,
    input  logic             rq0_cin,
    input  logic [WIDTH-1:0] rq1_a,
    input  logic [WIDTH-1:0] rq1_b,
    input  logic [OPW-1:0]   rq1_op,
    input  logic             rq1_cin,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [FLAGW-1:0] alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [FLAGW-1:0] rsp_flags,
    output logic             rsp_err
);
    import alu_ctrl_pkg::*;

    ctrlState_e       state, nextState;
    logic [1:0]       grant;
    logic             accept;
    logic             selId;
    logic [WIDTH-1:0] selA, selB;
    logic [OPW-1:0]   selOp;
    logic             selCin;
    logic             selLegal;
    logic             idReg;
    logic             errReg;

    alu_arb2 uArb (
        .clk     (clk),
        .rst_n   (rst_n),
        .rqValid (rq_valid),
        .accept  (accept),
        .grant   (grant)
    );

    assign rq_ready = (state == IDLE) ? grant : 2'b00;
    assign accept   = |(rq_valid & rq_ready);

    assign selId    = grant[1];
    assign selA     = selId ? rq1_a   : rq0_a;
    assign selB     = selId ? rq1_b   : rq0_b;
    assign selOp    = selId ? rq1_op  : rq0_op;
    assign selCin   = selId ? rq1_cin : rq0_cin;
    assign selLegal = (selOp < OPW'(NUM_OPS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept) nextState = EXEC;
            EXEC:    nextState = RESP;
            RESP:    if (rsp_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // ALU pins only change on accept so the ALU sees no activity while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            alu_cin    <= 1'b0;
            idReg      <= 1'b0;
            errReg     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                alu_a   <= selA;
                alu_b   <= selB;
                alu_op  <= selLegal ? selOp : '0;
                alu_cin <= selCin;
                idReg   <= selId;
                errReg  <= ~selLegal;
            end
            if (state == EXEC) begin
                rsp_valid  <= 1'b1;
                rsp_id     <= idReg;
                rsp_err    <= errReg;
                rsp_result <= errReg ? '0 : alu_result;
                rsp_flags  <= errReg ? '0 : alu_flags;
            end else if ((state == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl; models the ALU behaviourally and checks tagged responses.
module tb_alu_share_ctrl;
  localparam int W = 16;
  localparam int OW = 8;
  localparam int FW = 5;
  localparam int RW = 1 + 1 + FW + W;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] rq_valid;
  logic [1:0] rq_ready;
  logic [W-1:0] rq0_a, rq0_b, rq1_a, rq1_b;
  logic [OW-1:0] rq0_op, rq1_op;
  logic rq0_cin, rq1_cin;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [OW-1:0] alu_op;
  logic alu_cin;
  logic [FW-1:0] alu_flags;
  logic rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [W-1:0] rsp_result;
  logic [FW-1:0] rsp_flags;

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_q[$];
`ifdef ALU_SHARE_RR_EN
  logic rr_ptr;
`endif

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  alu_share_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .rq_valid(rq_valid), .rq_ready(rq_ready),
    .rq0_a(rq0_a), .rq0_b(rq0_b), .rq0_op(rq0_op), .rq0_cin(rq0_cin),
    .rq1_a(rq1_a), .rq1_b(rq1_b), .rq1_op(rq1_op), .rq1_cin(rq1_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
  );

  // behavioural ALU: returns {C,L,F,Z,N, result}
  function automatic logic [FW+W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [OW-1:0] op, input logic cin);
    logic [W:0] wide;
    logic [W-1:0] r;
    logic c, v;
    logic [2*W-1:0] dbl;
    int s;
    wide = '0; r = '0; c = 1'b0; v = 1'b0;
    s = int'(b[3:0]);
    dbl = {a, a};
    case (op)
      8'd0: begin wide = {1'b0, a} + {1'b0, b}; r = wide[W-1:0]; c = wide[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
      8'd1: begin wide = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin}; r = wide[W-1:0]; c = wide[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
      8'd2: begin wide = {1'b0, a} - {1'b0, b}; r = wide[W-1:0]; c = wide[W];
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
      8'd3: begin wide = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin}; r = wide[W-1:0]; c = wide[W];
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
      8'd4: r = a & b;
      8'd5: r = a | b;
      8'd6: r = a ^ b;
      8'd7: r = ~a;
      8'd8: r = a << s;
      8'd9: r = a >> s;
      8'd10: r = $signed(a) >>> s;
      8'd11: begin dbl = dbl << s; r = dbl[2*W-1:W]; end
      8'd12: begin dbl = dbl >> s; r = dbl[W-1:0]; end
      8'd13: r = a;
      8'd14: r = b;
      8'd15: r = a + 16'd1;
      8'd16: r = a - 16'd1;
      8'd17: r = 16'd0 - a;
      8'd18: begin wide = {1'b0, a} - {1'b0, b}; r = wide[W-1:0]; c = wide[W]; end
      8'd19: begin dbl = a * b; r = dbl[W-1:0]; end
      8'd20: r = (a < b) ? a : b;
      8'd21: r = (a > b) ? a : b;
      default: r = '0;
    endcase
    return {c, ($signed(a) < $signed(b)), v, (r == 16'd0), r[W-1], r};
  endfunction

  // expected response packed as {id, err, flags, result}
  function automatic logic [RW-1:0] expect_rsp(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [OW-1:0] op, input logic cin);
    if (op >= 8'd22) return {id, 1'b1, {FW{1'b0}}, {W{1'b0}}};
    return {id, 1'b0, alu_ref(a, b, op, cin)};
  endfunction

  always_comb begin
    {alu_flags, alu_result} = alu_ref(alu_a, alu_b, alu_op, alu_cin);
  end

  // driver tasks
  task automatic drive_req(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [OW-1:0] op, input logic cin);
    if (id) begin
      rq1_a = a; rq1_b = b; rq1_op = op; rq1_cin = cin; rq_valid[1] = 1'b1;
    end else begin
      rq0_a = a; rq0_b = b; rq0_op = op; rq0_cin = cin; rq_valid[0] = 1'b1;
    end
  endtask

  task automatic wait_rsp(output logic got, output int lat);
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rq_valid = 2'b00;
    rsp_ready = 1'b1;
    rq0_a = '0; rq0_b = '0; rq0_op = '0; rq0_cin = 1'b0;
    rq1_a = '0; rq1_b = '0; rq1_op = '0; rq1_cin = 1'b0;
`ifdef ALU_SHARE_RR_EN
    rr_ptr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [RW-1:0] rsp_pack();
    return {rsp_id, rsp_err, rsp_flags, rsp_result};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    rq_valid = 2'b00;
    rsp_ready = 1'b1;
    rq0_a = '0; rq0_b = '0; rq0_op = '0; rq0_cin = 1'b0;
    rq1_a = '0; rq1_b = '0; rq1_op = '0; rq1_cin = 1'b0;
    @(negedge clk);
    checks++;
    if (rq_ready !== 2'b00) begin errors++; $display("FAIL reset_rq_ready got %b exp 00", rq_ready); end
    checks++;
    if ({alu_a, alu_b, alu_op, alu_cin} !== '0) begin
      errors++; $display("FAIL reset_alu got %h %h %h %b exp zeros", alu_a, alu_b, alu_op, alu_cin);
    end
    checks++;
    if ({rsp_valid, rsp_pack()} !== '0) begin
      errors++; $display("FAIL reset_rsp got v=%b %h exp zeros", rsp_valid, rsp_pack());
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic got;
    int lat;
    @(posedge clk); #1;
    drive_req(1'b0, 16'd3, 16'd4, 8'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (rq_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b exp 01", rq_ready); end
    @(posedge clk); #1;
    rq_valid = 2'b00;
    checks++;
    if ({alu_a, alu_b, alu_op} !== {16'd3, 16'd4, 8'd0}) begin
      errors++; $display("FAIL single_alu_pins got %h %h %h exp 0003 0004 00", alu_a, alu_b, alu_op);
    end
    wait_rsp(got, lat);
    checks++;
    if (!got || lat != 2) begin errors++; $display("FAIL single_latency got %0d (seen %b) exp 2", lat, got); end
    checks++;
    if (rsp_pack() !== {1'b0, 1'b0, 5'b01000, 16'd7}) begin
      errors++; $display("FAIL single_rsp got %h exp %h", rsp_pack(), {1'b0, 1'b0, 5'b01000, 16'd7});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic got;
    int lat;
    logic [RW-1:0] e1, e2;
    logic [W-1:0] a, b;
    a = W'($urandom); b = W'($urandom);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    drive_req(1'b1, a, b, 8'd2, 1'b0);
    e1 = expect_rsp(1'b1, a, b, 8'd2, 1'b0);
    @(negedge clk);
    checks++;
    if (rq_ready !== 2'b10) begin errors++; $display("FAIL bp_ready1 got %b exp 10", rq_ready); end
    @(posedge clk); #1;
    rq_valid = 2'b00;
    a = W'($urandom); b = W'($urandom);
    drive_req(1'b0, a, b, 8'd6, 1'b0);
    e2 = expect_rsp(1'b0, a, b, 8'd6, 1'b0);
    wait_rsp(got, lat);
    checks++;
    if (!got || lat != 2) begin errors++; $display("FAIL bp_latency got %0d (seen %b) exp 2", lat, got); end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_pack()} !== {1'b1, e1}) begin
        errors++; $display("FAIL bp_hold cyc %0d got v=%b %h exp v=1 %h", i, rsp_valid, rsp_pack(), e1);
      end
      checks++;
      if (rq_ready !== 2'b00) begin errors++; $display("FAIL bp_ready_low cyc %0d got %b exp 00", i, rq_ready); end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rq_ready !== 2'b00) begin errors++; $display("FAIL bp_ready_resp got %b exp 00", rq_ready); end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rsp_valid, rq_ready} !== 3'b001) begin
      errors++; $display("FAIL bp_next_accept got v=%b rdy=%b exp v=0 rdy=01", rsp_valid, rq_ready);
    end
    @(posedge clk); #1;
    rq_valid = 2'b00;
    wait_rsp(got, lat);
    checks++;
    if (!got || rsp_pack() !== e2) begin errors++; $display("FAIL bp_second_rsp got %h exp %h", rsp_pack(), e2); end
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    logic got;
    int lat;
    logic exp_id;
    logic [RW-1:0] e;
    do_reset();
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drive_req(1'b0, 16'd10, 16'd1, 8'd0, 1'b0);
    drive_req(1'b1, 16'd20, 16'd2, 8'd2, 1'b0);
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_SHARE_RR_EN
      exp_id = k[0];
`else
      exp_id = 1'b0;
`endif
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (rq_ready != 2'b00) begin got = 1'b1; break; end
      end
      checks++;
      if (rq_ready !== (exp_id ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL cont_grant op %0d got %b exp id %0d (seen %b)", k, rq_ready, exp_id, got);
      end
      e = exp_id ? expect_rsp(1'b1, 16'd20, 16'd2, 8'd2, 1'b0) : expect_rsp(1'b0, 16'd10, 16'd1, 8'd0, 1'b0);
      @(posedge clk); #1;
      wait_rsp(got, lat);
      checks++;
      if (!got || rsp_pack() !== e) begin errors++; $display("FAIL cont_rsp op %0d got %h exp %h", k, rsp_pack(), e); end
      @(posedge clk); #1;
    end
    rq_valid = 2'b00;
  endtask

  task automatic test_illegal();
    logic got;
    int lat;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drive_req(1'b1, W'($urandom), W'($urandom), 8'd22, 1'($urandom_range(0, 1)));
    @(negedge clk);
    checks++;
    if (rq_ready !== 2'b10) begin errors++; $display("FAIL illegal_ready got %b exp 10", rq_ready); end
    @(posedge clk); #1;
    rq_valid = 2'b00;
    checks++;
    if (alu_op !== 8'd0) begin errors++; $display("FAIL illegal_alu_op got %h exp 00", alu_op); end
    wait_rsp(got, lat);
    checks++;
    if (!got || lat != 2) begin errors++; $display("FAIL illegal_latency got %0d (seen %b) exp 2", lat, got); end
    checks++;
    if (rsp_pack() !== {1'b1, 1'b1, 5'b0, 16'd0}) begin
      errors++; $display("FAIL illegal_rsp got %h exp %h", rsp_pack(), {1'b1, 1'b1, 5'b0, 16'd0});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    logic got;
    int lat;
    logic [RW-1:0] e;
    logic [W-1:0] a, b;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drive_req(1'b0, 16'h1234, 16'h0F0F, 8'd5, 1'b0);
    @(posedge clk); #1;
    rq_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rq_ready, alu_a, alu_b, alu_op, alu_cin, rsp_valid, rsp_pack()} !== '0) begin
      errors++; $display("FAIL midop_reset_vals got alu=%h/%h/%h rsp v=%b %h exp zeros", alu_a, alu_b, alu_op, rsp_valid, rsp_pack());
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
`ifdef ALU_SHARE_RR_EN
    rr_ptr = 1'b0;
`endif
    got = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    checks++;
    if (got !== 1'b0) begin errors++; $display("FAIL midop_no_rsp got rsp_valid=1 exp 0"); end
    @(posedge clk); #1;
    a = W'($urandom); b = W'($urandom);
    drive_req(1'b1, a, b, 8'd19, 1'b0);
    e = expect_rsp(1'b1, a, b, 8'd19, 1'b0);
    @(negedge clk);
    @(posedge clk); #1;
    rq_valid = 2'b00;
    wait_rsp(got, lat);
    checks++;
    if (!got || lat != 2 || rsp_pack() !== e) begin
      errors++; $display("FAIL midop_after got %h lat %0d exp %h lat 2", rsp_pack(), lat, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [1:0] v;
    logic g;
    logic got;
    logic [W-1:0] a0, b0, a1, b1;
    logic [OW-1:0] op0, op1;
    logic c0, c1;
    int issued, seen;
    issued = 0; seen = 0;
    do_reset();
    @(posedge clk); #1;
    for (int n = 0; n < 80; n++) begin
      v = 2'($urandom_range(1, 3));
      a0 = W'($urandom); b0 = W'($urandom); c0 = 1'($urandom_range(0, 1));
      a1 = W'($urandom); b1 = W'($urandom); c1 = 1'($urandom_range(0, 1));
      op0 = ($urandom_range(0, 9) == 0) ? OW'($urandom_range(22, 255)) : OW'($urandom_range(0, 21));
      op1 = ($urandom_range(0, 9) == 0) ? OW'($urandom_range(22, 255)) : OW'($urandom_range(0, 21));
      rq0_a = a0; rq0_b = b0; rq0_op = op0; rq0_cin = c0;
      rq1_a = a1; rq1_b = b1; rq1_op = op1; rq1_cin = c1;
      rq_valid = v;
`ifdef ALU_SHARE_RR_EN
      g = (v == 2'b11) ? rr_ptr : ~v[0];
      rr_ptr = ~g;
`else
      g = ~v[0];
`endif
      @(negedge clk);
      checks++;
      if (rq_ready !== (g ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rand_grant op %0d valid %b got %b exp id %0d", n, v, rq_ready, g);
      end
      @(posedge clk); #1;
      rq_valid = 2'b00;
      exp_q.push_back(g ? expect_rsp(1'b1, a1, b1, op1, c1) : expect_rsp(1'b0, a0, b0, op0, c0));
      issued++;
      rsp_ready = 1'($urandom_range(0, 1));
      got = 1'b0;
      for (int cyc = 0; cyc < 30; cyc++) begin
        @(negedge clk);
        if (rsp_valid) begin
          checks++;
          if (exp_q.size() == 0 || rsp_pack() !== exp_q[0]) begin
            errors++; $display("FAIL rand_rsp op %0d got %h exp %h", n, rsp_pack(), (exp_q.size() != 0) ? exp_q[0] : '0);
          end
          if (rsp_ready) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            seen++;
            got = 1'b1;
            break;
          end
        end
        @(posedge clk); #1;
        rsp_ready = (cyc >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      if (!got) begin
        checks++; errors++; $display("FAIL rand_timeout op %0d got no response exp one", n);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
    end
    checks++;
    if (seen != issued || exp_q.size() != 0) begin
      errors++; $display("FAIL rand_count got %0d responses exp %0d (left %0d)", seen, issued, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_contention();
    test_illegal();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
